// File: rtl/cheshire_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : cheshire_tick_gen
//  Description : Multi-channel programmable tick generator / clock divider.
//                Each channel produces a registered divided clock and a
//                one-cycle tick in the last cycle of every period. Divisor
//                updates to a running channel are held in a shadow register
//                and applied only at a period boundary.
//  Revision    : 1.0  initial release
// ============================================================================
module cheshire_tick_gen #(
    parameter int unsigned NumCh      = 2,
    parameter int unsigned DivWidth   = 16,
    parameter int unsigned DefaultDiv = 50,
    parameter int unsigned ChIdxW     = (NumCh > 1) ? $clog2(NumCh) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumCh-1:0]    en_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [ChIdxW-1:0]   cfg_ch_i,
    input  logic [DivWidth-1:0] cfg_div_i,
    output logic                cfg_err_o,
    output logic [NumCh-1:0]    pending_o,
    output logic [NumCh-1:0]    div_clk_o,
    output logic [NumCh-1:0]    tick_o
);

    localparam logic [DivWidth-1:0] DEF_DIV  = DivWidth'(DefaultDiv);
    localparam logic [DivWidth-1:0] ONE      = DivWidth'(1);
    localparam logic [DivWidth-1:0] MIN_DIV  = DivWidth'(2);
    localparam logic [ChIdxW:0]     NUM_CH_V = (ChIdxW + 1)'(NumCh);

    // Reject illegal configurations at elaboration time.
    if (NumCh < 1) begin : g_bad_numch
        $error("cheshire_tick_gen: NumCh must be at least 1");
    end
    if (DefaultDiv < 2 || (DefaultDiv >> DivWidth) != 0) begin : g_bad_default
        $error("cheshire_tick_gen: DefaultDiv must lie in 2 .. 2**DivWidth-1");
    end

    logic [NumCh-1:0] pend_q;
    logic             ch_valid;
    logic             ch_busy;
    logic             div_ok;
    logic             handshake;
    logic             accept;
    logic             reject;
    logic             err_q;

    // Handshake decode: a channel holding an unapplied divisor blocks new updates.
    always_comb begin
        ch_busy = 1'b0;
        for (int i = 0; i < int'(NumCh); i++) begin
            if (cfg_ch_i == ChIdxW'(i)) begin
                ch_busy = pend_q[i];
            end
        end
        ch_valid    = ({1'b0, cfg_ch_i} < NUM_CH_V);
        div_ok      = (cfg_div_i >= MIN_DIV);
        cfg_ready_o = ~ch_busy;
        handshake   = cfg_valid_i & cfg_ready_o;
        accept      = handshake & ch_valid & div_ok;
        reject      = handshake & ~(ch_valid & div_ok);
    end

    // Error pulse for one cycle after a rejected update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= reject;
        end
    end

    assign cfg_err_o = err_q;
    assign pending_o = pend_q;

    for (genvar i = 0; i < int'(NumCh); i++) begin : g_ch
        logic [DivWidth-1:0] cnt_q, cnt_d;
        logic [DivWidth-1:0] div_q, div_d;
        logic [DivWidth-1:0] shd_q, shd_d;
        logic                pnd_q, pnd_d;
        logic                out_q, tick_q;
        logic                wrap;
        logic                sel;

        // Next-state: count, wrap, apply shadow at boundary or on disable, take updates.
        always_comb begin
            cnt_d = cnt_q + ONE;
            div_d = div_q;
            shd_d = shd_q;
            pnd_d = pnd_q;
            wrap  = (cnt_q == div_q - ONE);
            sel   = accept & (cfg_ch_i == ChIdxW'(i));
            if (!en_i[i] || wrap) begin
                cnt_d = '0;
                if (pnd_q) begin
                    div_d = shd_q;
                    pnd_d = 1'b0;
                end
            end
            if (sel) begin
                if (en_i[i]) begin
                    shd_d = cfg_div_i;
                    pnd_d = 1'b1;
                end else begin
                    div_d = cfg_div_i;
                end
            end
        end

        // Channel state; outputs are registered images of the next count.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q  <= '0;
                div_q  <= DEF_DIV;
                shd_q  <= DEF_DIV;
                pnd_q  <= 1'b0;
                out_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                div_q  <= div_d;
                shd_q  <= shd_d;
                pnd_q  <= pnd_d;
                out_q  <= (cnt_d >= (div_d >> 1));
                tick_q <= (cnt_d == div_d - ONE);
            end
        end

        assign pend_q[i]    = pnd_q;
        assign div_clk_o[i] = out_q;
        assign tick_o[i]    = tick_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_cheshire_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cheshire_tick_gen
//  Description : Scoreboard bench for cheshire_tick_gen. A period-start model
//                predicts every output cycle; a negedge monitor compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cheshire_tick_gen;

    localparam int NCH = 3;
    localparam int DW  = 16;
    localparam int DEF = 50;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    en = '0;
    logic          cfg_valid = 1'b0;
    logic [1:0]    cfg_ch = '0;
    logic [DW-1:0] cfg_div = '0;
    logic          cfg_ready, cfg_err;
    logic [2:0]    pending, div_clk, tick;

    cheshire_tick_gen #(.NumCh(NCH), .DivWidth(DW), .DefaultDiv(DEF)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .cfg_ch_i(cfg_ch), .cfg_div_i(cfg_div), .cfg_err_o(cfg_err),
        .pending_o(pending), .div_clk_o(div_clk), .tick_o(tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] clk_e;
        logic [2:0] tick_e;
        logic [2:0] pend_e;
        logic       err_e;
        logic       rdy_e;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: each channel is described by the cycle its current
    // period began and its active divisor; position = now - start.
    int cyc = 0;
    int start[NCH];
    int dv[NCH];
    int shd[NCH];
    bit pm[NCH];
    bit err_m;

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            dv[i] = DEF; shd[i] = 0; pm[i] = 0; start[i] = cyc;
        end
        err_m = 0;
    endfunction

    function automatic bit model_ready(input logic [1:0] ch);
        if (int'(ch) < NCH) return !pm[ch];
        return 1'b1;
    endfunction

    function automatic void model_step();
        bit hs;
        if (!rst_n) begin
            cyc++;
            model_reset();
            return;
        end
        hs = cfg_valid && model_ready(cfg_ch);
        for (int i = 0; i < NCH; i++) begin
            if (!en[i] || (cyc - start[i]) == dv[i] - 1) begin
                start[i] = cyc + 1;
                if (pm[i]) begin dv[i] = shd[i]; pm[i] = 0; end
            end
        end
        err_m = 0;
        if (hs) begin
            if (cfg_div < 2 || int'(cfg_ch) >= NCH) err_m = 1;
            else if (!en[cfg_ch]) dv[cfg_ch] = int'(cfg_div);
            else begin shd[cfg_ch] = int'(cfg_div); pm[cfg_ch] = 1; end
        end
        cyc++;
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        int   pos;
        e = '0;
        for (int i = 0; i < NCH; i++) begin
            pos = cyc - start[i];
            e.clk_e[i]  = (pos >= dv[i] / 2);
            e.tick_e[i] = (pos == dv[i] - 1);
            e.pend_e[i] = pm[i];
        end
        e.err_e = err_m;
        e.rdy_e = model_ready(cfg_ch);
        return e;
    endfunction

    // Drive one cycle of stimulus, predict the outputs, then advance the model.
    task automatic cycle(input logic [2:0] e, input logic v, input logic [1:0] ch,
                         input logic [DW-1:0] d);
        en = e; cfg_valid = v; cfg_ch = ch; cfg_div = d;
        sb.push_back(model_expect());
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run(input int n, input logic [2:0] e);
        repeat (n) cycle(e, 1'b0, 2'd0, '0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        repeat (n) cycle(3'b000, 1'b0, 2'd0, '0);
        rst_n = 1'b1;
    endtask

    task automatic wait_pos(input int ch, input int p, input logic [2:0] e);
        int n = 0;
        while ((cyc - start[ch]) != p && n < 300) begin
            cycle(e, 1'b0, 2'd0, '0);
            n++;
        end
        if (n >= 300) begin
            vectors++; miscompares++;
            $display("FAIL wait_pos ch%0d: position %0d never reached, got %0d", ch, p,
                     cyc - start[ch]);
        end
    endtask

    function automatic void check(input string name, input logic [2:0] got,
                                  input logic [2:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, got, want);
        end
    endfunction

    // Monitor: every cycle the DUT presents a full output word; pop and compare.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("div_clk", div_clk, e.clk_e);
            check("tick", tick, e.tick_e);
            check("pending", pending, e.pend_e);
            check("cfg_err", {2'b00, cfg_err}, {2'b00, e.err_e});
            check("cfg_ready", {2'b00, cfg_ready}, {2'b00, e.rdy_e});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]    ren;
        logic [DW-1:0] rd;
        int            r;
        @(posedge clk); #1;
        do_reset(3);

        // Default divisor on channel 0.
        run(110, 3'b001);

        // Update a disabled channel, then enable it.
        cycle(3'b001, 1'b1, 2'd1, 16'd5);
        run(25, 3'b011);

        // Running update applies only at the next wrap; second update blocked.
        wait_pos(0, 10, 3'b011);
        cycle(3'b011, 1'b1, 2'd0, 16'd10);
        cycle(3'b011, 1'b1, 2'd0, 16'd7);
        cycle(3'b011, 1'b1, 2'd1, 16'd6);
        run(90, 3'b011);

        // Rejected updates: divisor too small, channel out of range.
        cycle(3'b011, 1'b1, 2'd0, 16'd0);
        run(2, 3'b011);
        cycle(3'b011, 1'b1, 2'd1, 16'd1);
        run(2, 3'b011);
        cycle(3'b011, 1'b1, 2'd3, 16'd9);
        run(30, 3'b011);

        // Disable during the high phase with an update pending, then re-enable.
        wait_pos(0, 5, 3'b011);
        cycle(3'b011, 1'b1, 2'd0, 16'd8);
        run(4, 3'b010);
        run(30, 3'b011);

        // Asynchronous reset in mid-period with an update pending.
        wait_pos(0, 3, 3'b011);
        cycle(3'b011, 1'b1, 2'd0, 16'd20);
        run(2, 3'b011);
        do_reset(3);
        cycle(3'b001, 1'b0, 2'd0, '0);
        run(60, 3'b001);

        // Randomised traffic with one reset in the middle.
        ren = 3'b111;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 63) == 0) ren[$urandom_range(0, 2)] ^= 1'b1;
            r = $urandom_range(0, 9);
            if (r == 0)      rd = DW'($urandom_range(0, 1));
            else if (r == 1) rd = DW'($urandom_range(13, 70));
            else             rd = DW'($urandom_range(2, 12));
            if (k == 700) do_reset(2);
            cycle(ren, ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)), rd);
        end

        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
